// File: rtl/axis_fxp_mac_pkg.sv
// Width helpers and default derived widths for the multi-lane fixed-point MAC.
// Saturation limits are produced by functions so any output width can use them.
package axis_fxp_mac_pkg;

    function automatic int unsigned fxp_p_w(input int unsigned int_a, input int unsigned frac_a,
                                            input int unsigned int_b, input int unsigned frac_b);
        return int_a + frac_a + int_b + frac_b;
    endfunction

    function automatic int unsigned fxp_acc_w(input int unsigned p_w, input int unsigned guard);
        return p_w + guard;
    endfunction

    function automatic int unsigned fxp_o_w(input int unsigned out_int,
                                            input int unsigned out_frac);
        return out_int + out_frac;
    endfunction

    function automatic int unsigned fxp_sh(input int unsigned frac_a, input int unsigned frac_b,
                                           input int unsigned out_frac);
        return frac_a + frac_b - out_frac;
    endfunction

    // Largest and smallest two's-complement values of a w-bit signed word.
    function automatic logic signed [63:0] fxp_max(input int unsigned w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] fxp_min(input int unsigned w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    localparam int unsigned P_W   = fxp_p_w(6, 8, 6, 8);
    localparam int unsigned ACC_W = fxp_acc_w(P_W, 4);
    localparam int unsigned O_W   = fxp_o_w(12, 8);
    localparam int unsigned SH    = fxp_sh(8, 8, 8);

endpackage

// File: rtl/fxp_round_sat.sv
// Combinational rescale of one accumulator: optional round-half-up, arithmetic
// shift right, then saturation to the output word with clip flags.
module fxp_round_sat
    import axis_fxp_mac_pkg::*;
#(
    parameter int unsigned ACC_W    = axis_fxp_mac_pkg::ACC_W,
    parameter int unsigned O_W      = axis_fxp_mac_pkg::O_W,
    parameter int unsigned SH       = axis_fxp_mac_pkg::SH,
    parameter bit          ROUND_EN = 1'b1
) (
    input  logic signed [ACC_W-1:0] acc_i,
    output logic        [O_W-1:0]   data_o,
    output logic                    ovf_o,
    output logic                    unf_o
);

    localparam int unsigned EXT_W = ACC_W + 1;
    localparam logic signed [EXT_W-1:0] MaxV = EXT_W'(fxp_max(O_W));
    localparam logic signed [EXT_W-1:0] MinV = EXT_W'(fxp_min(O_W));

    logic signed [EXT_W-1:0] bias;
    logic signed [EXT_W-1:0] rounded;
    logic signed [EXT_W-1:0] shifted;

    if (ROUND_EN && SH > 0) begin : g_round
        assign bias = EXT_W'(1) << (SH - 1);
    end else begin : g_trunc
        assign bias = '0;
    end

    // One extra bit keeps the rounding add from wrapping at the accumulator max.
    assign rounded = $signed({acc_i[ACC_W-1], acc_i}) + bias;
    assign shifted = rounded >>> SH;

    always_comb begin
        ovf_o  = shifted > MaxV;
        unf_o  = shifted < MinV;
        data_o = shifted[O_W-1:0];
        if (ovf_o) begin
            data_o = MaxV[O_W-1:0];
        end else if (unf_o) begin
            data_o = MinV[O_W-1:0];
        end
    end

endmodule

// File: rtl/axis_fxp_mac.sv
// Multi-lane fixed-point multiply-accumulate with valid/ready streams: stage 1
// registers products, stage 2 accumulates and loads the rescaled result on last.
module axis_fxp_mac
    import axis_fxp_mac_pkg::*;
#(
    parameter int unsigned LANES     = 4,
    parameter int unsigned INT_A     = 6,
    parameter int unsigned FRAC_A    = 8,
    parameter int unsigned INT_B     = 6,
    parameter int unsigned FRAC_B    = 8,
    parameter int unsigned ACC_GUARD = 4,
    parameter int unsigned OUT_INT   = 12,
    parameter int unsigned OUT_FRAC  = 8,
    parameter bit          ROUND_EN  = 1'b1
) (
    input  logic                                   clock,
    input  logic                                   rst,
    input  logic [LANES*(INT_A+FRAC_A)-1:0]        s_a,
    input  logic [LANES*(INT_B+FRAC_B)-1:0]        s_b,
    input  logic                                   s_valid,
    input  logic                                   s_last,
    output logic                                   s_ready,
    output logic [LANES*(OUT_INT+OUT_FRAC)-1:0]    m_data,
    output logic [LANES-1:0]                       m_ovf,
    output logic [LANES-1:0]                       m_unf,
    output logic                                   m_valid,
    input  logic                                   m_ready
);

    localparam int unsigned A_W    = INT_A + FRAC_A;
    localparam int unsigned B_W    = INT_B + FRAC_B;
    localparam int unsigned PROD_W = fxp_p_w(INT_A, FRAC_A, INT_B, FRAC_B);
    localparam int unsigned ACCU_W = fxp_acc_w(PROD_W, ACC_GUARD);
    localparam int unsigned RES_W  = fxp_o_w(OUT_INT, OUT_FRAC);
    localparam int unsigned SHIFT  = fxp_sh(FRAC_A, FRAC_B, OUT_FRAC);

    localparam logic signed [ACCU_W-1:0] AccMax = {1'b0, {(ACCU_W-1){1'b1}}};
    localparam logic signed [ACCU_W-1:0] AccMin = {1'b1, {(ACCU_W-1){1'b0}}};

    logic                      en;
    logic                      s1_valid_q;
    logic                      s1_last_q;
    logic [LANES*PROD_W-1:0]   s1_prod_q;
    logic [LANES*PROD_W-1:0]   prod_d;
    logic                      m_valid_q;

    // The whole pipeline advances together whenever the output slot is free.
    assign en      = !m_valid_q || m_ready;
    assign s_ready = en;
    assign m_valid = m_valid_q;

    always_ff @(posedge clock) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_prod_q  <= '0;
            m_valid_q  <= 1'b0;
        end else if (en) begin
            s1_valid_q <= s_valid;
            if (s_valid) begin
                s1_last_q <= s_last;
                s1_prod_q <= prod_d;
            end
            m_valid_q <= s1_valid_q && s1_last_q;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic        [A_W-1:0]    a;
        logic        [B_W-1:0]    b;
        logic signed [PROD_W-1:0] prod;
        logic signed [ACCU_W-1:0] acc_q;
        logic signed [ACCU_W:0]   sum_wide;
        logic signed [ACCU_W-1:0] sum;
        logic                     add_ovf;
        logic                     add_unf;
        logic                     acc_ovf_q;
        logic                     acc_unf_q;
        logic        [RES_W-1:0]  rs_data;
        logic                     rs_ovf;
        logic                     rs_unf;
        logic        [RES_W-1:0]  data_q;
        logic                     ovf_q;
        logic                     unf_q;

        assign a = s_a[i*A_W +: A_W];
        assign b = s_b[i*B_W +: B_W];
        assign prod_d[i*PROD_W +: PROD_W] =
            $signed({{B_W{a[A_W-1]}}, a}) * $signed({{A_W{b[B_W-1]}}, b});

        assign prod     = s1_prod_q[i*PROD_W +: PROD_W];
        assign sum_wide = {acc_q[ACCU_W-1], acc_q}
                        + {{(ACCU_W + 1 - PROD_W){prod[PROD_W-1]}}, prod};
        assign add_ovf  = !sum_wide[ACCU_W] && sum_wide[ACCU_W-1];
        assign add_unf  = sum_wide[ACCU_W] && !sum_wide[ACCU_W-1];

        always_comb begin
            sum = sum_wide[ACCU_W-1:0];
            if (add_ovf) begin
                sum = AccMax;
            end else if (add_unf) begin
                sum = AccMin;
            end
        end

        fxp_round_sat #(
            .ACC_W    (ACCU_W),
            .O_W      (RES_W),
            .SH       (SHIFT),
            .ROUND_EN (ROUND_EN)
        ) u_round_sat (
            .acc_i  (sum),
            .data_o (rs_data),
            .ovf_o  (rs_ovf),
            .unf_o  (rs_unf)
        );

        always_ff @(posedge clock) begin
            if (rst) begin
                acc_q     <= '0;
                acc_ovf_q <= 1'b0;
                acc_unf_q <= 1'b0;
                data_q    <= '0;
                ovf_q     <= 1'b0;
                unf_q     <= 1'b0;
            end else if (en && s1_valid_q) begin
                if (s1_last_q) begin
                    acc_q     <= '0;
                    acc_ovf_q <= 1'b0;
                    acc_unf_q <= 1'b0;
                    data_q    <= rs_data;
                    ovf_q     <= acc_ovf_q || add_ovf || rs_ovf;
                    unf_q     <= acc_unf_q || add_unf || rs_unf;
                end else begin
                    acc_q     <= sum;
                    acc_ovf_q <= acc_ovf_q || add_ovf;
                    acc_unf_q <= acc_unf_q || add_unf;
                end
            end
        end

        assign m_data[i*RES_W +: RES_W] = data_q;
        assign m_ovf[i]                 = ovf_q;
        assign m_unf[i]                 = unf_q;
    end

endmodule

// File: tb/tb_axis_fxp_mac.sv
// Directed bench for axis_fxp_mac: default Q-formats, a rounding and a truncating
// instance fed identical streams, outputs sampled 1 time unit after each edge.
module tb_axis_fxp_mac;

    localparam int unsigned LANES = 4;
    localparam int unsigned A_W   = 14;
    localparam int unsigned B_W   = 14;
    localparam int unsigned O_W   = 20;

    logic                   clock = 1'b0;
    logic                   rst;
    logic [LANES*A_W-1:0]   s_a;
    logic [LANES*B_W-1:0]   s_b;
    logic                   s_valid;
    logic                   s_last;
    logic                   m_ready;

    logic                   s_ready;
    logic [LANES*O_W-1:0]   m_data;
    logic [LANES-1:0]       m_ovf;
    logic [LANES-1:0]       m_unf;
    logic                   m_valid;

    logic                   s_ready_t;
    logic [LANES*O_W-1:0]   m_data_t;
    logic [LANES-1:0]       m_ovf_t;
    logic [LANES-1:0]       m_unf_t;
    logic                   m_valid_t;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clock = ~clock;

    axis_fxp_mac dut (
        .clock   (clock),
        .rst     (rst),
        .s_a     (s_a),
        .s_b     (s_b),
        .s_valid (s_valid),
        .s_last  (s_last),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_ovf   (m_ovf),
        .m_unf   (m_unf),
        .m_valid (m_valid),
        .m_ready (m_ready)
    );

    axis_fxp_mac #(
        .ROUND_EN (1'b0)
    ) dut_t (
        .clock   (clock),
        .rst     (rst),
        .s_a     (s_a),
        .s_b     (s_b),
        .s_valid (s_valid),
        .s_last  (s_last),
        .s_ready (s_ready_t),
        .m_data  (m_data_t),
        .m_ovf   (m_ovf_t),
        .m_unf   (m_unf_t),
        .m_valid (m_valid_t),
        .m_ready (m_ready)
    );

    function automatic logic [LANES*A_W-1:0] pk14(input logic [13:0] l0, input logic [13:0] l1,
                                                  input logic [13:0] l2, input logic [13:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [LANES*O_W-1:0] pk20(input logic [19:0] l0, input logic [19:0] l1,
                                                  input logic [19:0] l2, input logic [19:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Sends nbeats identical beats (last on the final one), then idles one edge so
    // the result is visible on return.
    task automatic run_packet(input logic [LANES*A_W-1:0] a, input logic [LANES*B_W-1:0] b,
                              input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            s_a     = a;
            s_b     = b;
            s_valid = 1'b1;
            s_last  = (i == nbeats - 1);
            tick();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        s_a     = '0;
        s_b     = '0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        vec_cnt++;
        if (m_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_valid: got %b want 0", m_valid);
        end
        vec_cnt++;
        if (m_data !== '0) begin
            err_cnt++;
            $display("FAIL reset_data: got %h want 0", m_data);
        end
        vec_cnt++;
        if (m_ovf !== 4'b0 || m_unf !== 4'b0) begin
            err_cnt++;
            $display("FAIL reset_flags: got ovf %b unf %b want 0000 0000", m_ovf, m_unf);
        end
        vec_cnt++;
        if (s_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL reset_ready: got %b want 1", s_ready);
        end
    endtask

    task automatic test_single();
        logic [LANES*O_W-1:0] exp;
        exp     = pk20(20'h00300, 20'h0, 20'h0, 20'h0);
        s_a     = pk14(14'h0180, 14'h0, 14'h0, 14'h0);
        s_b     = pk14(14'h0200, 14'h0, 14'h0, 14'h0);
        s_valid = 1'b1;
        s_last  = 1'b1;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
        vec_cnt++;
        if (m_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL single_early: m_valid got %b want 0 after edge k", m_valid);
        end
        tick();
        vec_cnt++;
        if (m_valid !== 1'b1) begin
            err_cnt++;
            $display("FAIL single_valid: got %b want 1 after edge k+1", m_valid);
        end
        vec_cnt++;
        if (m_data !== exp) begin
            err_cnt++;
            $display("FAIL single_data: got %h want %h", m_data, exp);
        end
        vec_cnt++;
        if (m_ovf !== 4'b0 || m_unf !== 4'b0) begin
            err_cnt++;
            $display("FAIL single_flags: got ovf %b unf %b want 0000 0000", m_ovf, m_unf);
        end
        tick();
        vec_cnt++;
        if (m_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL single_drain: m_valid got %b want 0", m_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [LANES*O_W-1:0] exp;
        exp = pk20(20'h00400, 20'h00400, 20'h00400, 20'h00400);
        for (int i = 0; i < 8; i++) begin
            s_a     = pk14(14'h0100, 14'h0100, 14'h0100, 14'h0100);
            s_b     = pk14(14'h0100, 14'h0100, 14'h0100, 14'h0100);
            s_valid = 1'b1;
            s_last  = (i % 4 == 3);
            vec_cnt++;
            if (s_ready !== 1'b1) begin
                err_cnt++;
                $display("FAIL b2b_ready beat %0d: got %b want 1", i, s_ready);
            end
            tick();
            vec_cnt++;
            if (m_valid !== (i == 4)) begin
                err_cnt++;
                $display("FAIL b2b_valid beat %0d: got %b want %b", i, m_valid, (i == 4));
            end
            if (i == 4) begin
                vec_cnt++;
                if (m_data !== exp) begin
                    err_cnt++;
                    $display("FAIL b2b_data1: got %h want %h", m_data, exp);
                end
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        tick();
        vec_cnt++;
        if (m_valid !== 1'b1 || m_data !== exp) begin
            err_cnt++;
            $display("FAIL b2b_data2: got v=%b %h want v=1 %h", m_valid, m_data, exp);
        end
        tick();
        vec_cnt++;
        if (m_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL b2b_drain: m_valid got %b want 0", m_valid);
        end
    endtask

    task automatic test_saturation();
        logic [LANES*O_W-1:0] exp;
        exp = pk20(20'h7FFFF, 20'h80000, 20'h00300, 20'h00300);
        run_packet(pk14(14'h1FFF, 14'h2000, 14'h0100, 14'h0100),
                   pk14(14'h1FFF, 14'h1FFF, 14'h0100, 14'h0100), 3);
        vec_cnt++;
        if (m_valid !== 1'b1 || m_data !== exp) begin
            err_cnt++;
            $display("FAIL sat_data: got v=%b %h want v=1 %h", m_valid, m_data, exp);
        end
        vec_cnt++;
        if (m_ovf !== 4'b0001) begin
            err_cnt++;
            $display("FAIL sat_ovf: got %b want 0001", m_ovf);
        end
        vec_cnt++;
        if (m_unf !== 4'b0010) begin
            err_cnt++;
            $display("FAIL sat_unf: got %b want 0010", m_unf);
        end
        tick();
    endtask

    task automatic test_rounding();
        logic [LANES*O_W-1:0] exp_r;
        logic [LANES*O_W-1:0] exp_t;
        // Products: +128, -128, +127, -129 LSBs of Q.16, shifted by 8.
        exp_r = pk20(20'h00001, 20'h00000, 20'h00000, 20'hFFFFF);
        exp_t = pk20(20'h00000, 20'hFFFFF, 20'h00000, 20'hFFFFF);
        run_packet(pk14(14'h0001, 14'h3FFF, 14'h0001, 14'h3FFF),
                   pk14(14'h0080, 14'h0080, 14'h007F, 14'h0081), 1);
        vec_cnt++;
        if (m_valid !== 1'b1 || m_data !== exp_r) begin
            err_cnt++;
            $display("FAIL round_on: got v=%b %h want v=1 %h", m_valid, m_data, exp_r);
        end
        vec_cnt++;
        if (m_valid_t !== 1'b1 || m_data_t !== exp_t) begin
            err_cnt++;
            $display("FAIL round_off: got v=%b %h want v=1 %h", m_valid_t, m_data_t, exp_t);
        end
        vec_cnt++;
        if (m_ovf !== 4'b0 || m_unf !== 4'b0 || m_ovf_t !== 4'b0 || m_unf_t !== 4'b0) begin
            err_cnt++;
            $display("FAIL round_flags: got %b %b %b %b want all 0000",
                     m_ovf, m_unf, m_ovf_t, m_unf_t);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [LANES*O_W-1:0] exp_a;
        logic [LANES*O_W-1:0] exp_b;
        logic [LANES*O_W-1:0] exp_c;
        exp_a   = pk20(20'h00100, 20'h00100, 20'h00100, 20'h00100);
        exp_b   = pk20(20'h00200, 20'h00200, 20'h00200, 20'h00200);
        exp_c   = pk20(20'h00300, 20'h00300, 20'h00300, 20'h00300);
        m_ready = 1'b0;
        s_b     = pk14(14'h0100, 14'h0100, 14'h0100, 14'h0100);
        s_a     = pk14(14'h0100, 14'h0100, 14'h0100, 14'h0100);
        s_valid = 1'b1;
        s_last  = 1'b1;
        tick();
        s_a = pk14(14'h0200, 14'h0200, 14'h0200, 14'h0200);
        tick();
        vec_cnt++;
        if (m_valid !== 1'b1 || m_data !== exp_a) begin
            err_cnt++;
            $display("FAIL bp_first: got v=%b %h want v=1 %h", m_valid, m_data, exp_a);
        end
        s_a = pk14(14'h0300, 14'h0300, 14'h0300, 14'h0300);
        for (int i = 0; i < 5; i++) begin
            vec_cnt++;
            if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_data !== exp_a) begin
                err_cnt++;
                $display("FAIL bp_hold cycle %0d: got rdy=%b v=%b %h want rdy=0 v=1 %h",
                         i, s_ready, m_valid, m_data, exp_a);
            end
            tick();
        end
        vec_cnt++;
        if (m_data !== exp_a) begin
            err_cnt++;
            $display("FAIL bp_hold_end: got %h want %h", m_data, exp_a);
        end
        m_ready = 1'b1;
        #1;
        vec_cnt++;
        if (s_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL bp_release_ready: got %b want 1", s_ready);
        end
        tick();
        vec_cnt++;
        if (m_valid !== 1'b1 || m_data !== exp_b) begin
            err_cnt++;
            $display("FAIL bp_second: got v=%b %h want v=1 %h", m_valid, m_data, exp_b);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        tick();
        vec_cnt++;
        if (m_valid !== 1'b1 || m_data !== exp_c) begin
            err_cnt++;
            $display("FAIL bp_third: got v=%b %h want v=1 %h", m_valid, m_data, exp_c);
        end
        tick();
        vec_cnt++;
        if (m_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL bp_drain: m_valid got %b want 0", m_valid);
        end
    endtask

    task automatic test_mid_reset();
        logic [LANES*O_W-1:0] exp;
        exp     = pk20(20'h00100, 20'h00100, 20'h00100, 20'h00100);
        m_ready = 1'b1;
        s_a     = pk14(14'h0100, 14'h0100, 14'h0100, 14'h0100);
        s_b     = pk14(14'h0100, 14'h0100, 14'h0100, 14'h0100);
        s_valid = 1'b1;
        s_last  = 1'b0;
        tick();
        tick();
        s_valid = 1'b0;
        rst     = 1'b1;
        tick();
        rst = 1'b0;
        vec_cnt++;
        if (m_valid !== 1'b0 || m_data !== '0) begin
            err_cnt++;
            $display("FAIL mrst_clear: got v=%b %h want v=0 0", m_valid, m_data);
        end
        run_packet(pk14(14'h0100, 14'h0100, 14'h0100, 14'h0100),
                   pk14(14'h0100, 14'h0100, 14'h0100, 14'h0100), 1);
        vec_cnt++;
        if (m_valid !== 1'b1 || m_data !== exp) begin
            err_cnt++;
            $display("FAIL mrst_data: got v=%b %h want v=1 %h", m_valid, m_data, exp);
        end
        vec_cnt++;
        if (m_ovf !== 4'b0 || m_unf !== 4'b0) begin
            err_cnt++;
            $display("FAIL mrst_flags: got ovf %b unf %b want 0000 0000", m_ovf, m_unf);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_saturation();
        test_rounding();
        test_backpressure();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axis_fxp_mac.md
Name: axis_fxp_mac

Overview:
- Multi-lane, parametrised fixed-point multiply-accumulate engine with valid/ready stream handshakes on input and output.
- Each accepted beat carries LANES operand pairs; each lane accumulates its own products until a beat tagged s_last.
- On s_last, each lane's sum is rescaled, optionally rounded, and saturated to a configurable output Q-format, with per-lane overflow/underflow flags.
- Successor to the single-lane MAC. Sits between the stream datapath and downstream filter/matrix logic.

Parameters:
LANES, 4, number of independent MAC lanes
INT_A, 6, integer bits of operand a (including sign)
FRAC_A, 8, fraction bits of operand a
INT_B, 6, integer bits of operand b
FRAC_B, 8, fraction bits of operand b
ACC_GUARD, 4, extra accumulator MSBs above the product width
OUT_INT, 12, integer bits of the result (including sign)
OUT_FRAC, 8, fraction bits of the result; must be <= FRAC_A+FRAC_B
ROUND_EN, 1, 1 = round half toward +inf on rescale, 0 = truncate

Ports:
clock  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
s_a  in  LANES*(INT_A+FRAC_A)  signed operand a per lane; lane i at slice i
s_b  in  LANES*(INT_B+FRAC_B)  signed operand b per lane
s_valid  in  1  input beat valid
s_last  in  1  final beat of the packet
s_ready  out  1  engine can accept a beat
m_data  out  LANES*(OUT_INT+OUT_FRAC)  signed per-lane result
m_ovf  out  LANES  lane result clipped to positive max
m_unf  out  LANES  lane result clipped to negative min
m_valid  out  1  result valid
m_ready  in  1  downstream accepts the result

Behaviour:
- Reset: all registers clear on a clock edge with rst=1. m_valid=0, m_data=0, m_ovf=0, m_unf=0, accumulators=0. Any partial packet is discarded. rst overrides every other event in the same cycle.
- Widths:
  - Product P_W = INT_A+INT_B+FRAC_A+FRAC_B, exact signed product.
  - Accumulator ACC_W = P_W+ACC_GUARD.
  - Shift SH = FRAC_A+FRAC_B-OUT_FRAC.
- Pipeline enable: en = !m_valid || m_ready. s_ready = en. s_ready is combinational from m_ready; this is intentional.
- Stage 1: on an edge with s_valid && en, register the LANES products plus last and valid flags. When en=0, stage 1 holds its contents.
- Stage 2, per lane, on an edge with en and stage-1 valid:
  - sum = acc + product, saturated to ACC_W.
  - Saturation sets sticky lane flags acc_ovf/acc_unf.
  - If stage-1 last=0: acc <= sum.
  - If stage-1 last=1: load the output register from sum via rescale; acc <= 0; sticky flags clear. The next packet starts with no bubble.
- Rescale:
  - If ROUND_EN && SH>0: add 2^(SH-1) in ACC_W+1 bits.
  - Arithmetic shift right by SH.
  - Saturate to OUT_INT+OUT_FRAC bits.
  - m_ovf = sticky acc_ovf OR positive clip. m_unf = sticky acc_unf OR negative clip.
- Latency: a last beat handshaken on edge k produces m_valid=1 after edge k+1.
- Output hold: m_valid=1 && m_ready=0 freezes m_data, m_ovf, m_unf and both stages. s_ready=0 during the hold.
- Output handshake: m_valid clears on an m_valid && m_ready edge unless a new result loads on the same edge; in that case m_valid stays 1 and the new data replaces the old.
- Single-beat packet (s_last on the first beat): result is the rescaled single product.
- Idle: s_valid=0 inserts a bubble. Accumulators hold across bubbles within a packet.
- There is no packet-length limit. Sums beyond the ACC_W range saturate and set the flags.

Decomposition:
- Package axis_fxp_mac_pkg holds width helper functions and localparams: P_W, ACC_W, O_W, SH, and the saturation min/max constants.
- One sub-module, fxp_round_sat, instantiated once per lane. It is combinational: ACC_W input, round/shift/saturate, O_W output plus ovf/unf.
- Lane replication uses a generate loop in axis_fxp_mac.

Test Plan:
- Defaults. One beat with lane0 a=0x0180 (1.5), b=0x0200 (2.0), s_last=1 -> m_data lane0=0x00300 (3.0) after edge k+1; ovf=unf=0.
- 4-beat packet, all lanes a=b=0x0100 (1.0) -> each lane=0x00400 (4.0). A second packet follows back-to-back with no bubble and m_ready=1 -> it also produces 4.0; s_ready stays 1 throughout.
- Saturation, 3 beats:
  - lane0 a=b=0x1FFF gives sum ~3071 -> lane0=0x7FFFF, m_ovf[0]=1.
  - lane1 a=0x2000 (-32), b=0x1FFF gives sum ~-3071 -> lane1=0x80000, m_unf[1]=1.
  - Other lanes are unflagged.
- Rounding: a=0x0001, b=0x0080 (exact value 2^-9).
  - ROUND_EN=1 -> 0x00001.
  - ROUND_EN=0 -> 0x00000.
- Backpressure: hold m_ready=0 for 5 cycles with a result pending -> m_data/m_valid stable and s_ready=0. Raise m_ready -> the pipelined next result appears on the following edge.
- Mid-packet reset: accept 2 beats, pulse rst, then send a 1-beat packet a=b=0x0100 -> result 0x00100. The pre-reset beats are not included.
